// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single-port 32-bit data RAM between instruction fetch (IF,
// read-only) and load/store (LS, read/write). One RAM access is issued per
// cycle. Each requester uses a req/gnt handshake and later receives an
// rvalid response. Reads respond exactly one cycle after the grant. Faulted
// accesses (misaligned or out of range) respond in the same way, with err=1.
// Good writes produce no response.
//
// The RAM registers address and write data on the clock edge. Its read data
// is unregistered and appears in the following cycle. The response stage
// therefore passes ram_rdata straight through to the owner of the response.
//
// Configuration:
//   MEM_PORT_ARB_RR_EN  defined   -> round-robin arbitration on a conflict
//                       undefined -> fixed priority, LS wins over IF
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                IF read request and byte address
//   if_gnt                        IF accepted this cycle (combinational)
//   if_rvalid/if_rdata/if_err     IF response (registered valid/err)
//   ls_req/ls_we/ls_addr/ls_wdata LS request, direction, address, write data
//   ls_gnt                        LS accepted this cycle (combinational)
//   ls_rvalid/ls_rdata/ls_err     LS response (reads and faulted writes)
//   ram_addr/ram_we/ram_wdata     RAM command, valid in the grant cycle
//   ram_rdata                     RAM read data, one cycle after the address
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_LS = 1'b1;

   // A byte address is faulty if it is not word aligned, or if it has any
   // bit set above the RAM's word-address range.
   function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || ((a >> (RAM_AW + 2)) != '0);
   endfunction

   // Response stage and held RAM address
   logic              rsp_pending_q, rsp_pending_d;
   logic              rsp_owner_q,   rsp_owner_d;
   logic              rsp_err_q,     rsp_err_d;
   logic [RAM_AW-1:0] ram_addr_q,    ram_addr_d;

`ifdef MEM_PORT_ARB_RR_EN
   logic              last_gnt_q,    last_gnt_d;
`endif

   // Grant-cycle datapath
   logic              sel_ls;
   logic              any_gnt;
   logic [ADDR_W-1:0] gnt_addr;
   logic              gnt_fault;

   // ---------------------------------------------------------------------------
   // Arbitration. sel_ls chooses LS over IF. The final grants are then
   // qualified by the matching request and by reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave it
      // unassigned and infer a latch.
      sel_ls = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      if (ls_req && if_req) begin
         // On a conflict, the side that was not granted last time wins.
         sel_ls = (last_gnt_q == OWNER_IF);
      end else begin
         sel_ls = ls_req;
      end
`else
      sel_ls = ls_req;
`endif
      ls_gnt  = !rst && ls_req && sel_ls;
      if_gnt  = !rst && if_req && !sel_ls;
      any_gnt = if_gnt || ls_gnt;
   end

   // ---------------------------------------------------------------------------
   // RAM command and next-state values for the response stage
   // ---------------------------------------------------------------------------
   always_comb begin
      gnt_addr  = ls_gnt ? ls_addr : if_addr;
      gnt_fault = any_gnt && addr_fault(gnt_addr);

      // Without a grant the RAM address stays where it was, so the RAM port
      // does not toggle on idle cycles.
      ram_addr  = any_gnt ? gnt_addr[RAM_AW+1:2] : ram_addr_q;
      ram_we    = ls_gnt && ls_we && !gnt_fault;
      ram_wdata = ram_we ? ls_wdata : '0;

      // Reads always respond. Writes respond only when they faulted.
      rsp_pending_d = any_gnt && (gnt_fault || !(ls_gnt && ls_we));
      rsp_owner_d   = any_gnt ? (ls_gnt ? OWNER_LS : OWNER_IF) : rsp_owner_q;
      rsp_err_d     = gnt_fault;
      ram_addr_d    = ram_addr;
`ifdef MEM_PORT_ARB_RR_EN
      last_gnt_d    = any_gnt ? (ls_gnt ? OWNER_LS : OWNER_IF) : last_gnt_q;
`endif
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset clears rsp_pending_q. This drops any read that is
   // still outstanding.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_pending_q <= 1'b0;
         rsp_owner_q   <= OWNER_IF;
         rsp_err_q     <= 1'b0;
         ram_addr_q    <= '0;
`ifdef MEM_PORT_ARB_RR_EN
         last_gnt_q    <= OWNER_IF;
`endif
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the
         // pre-edge values regardless of statement order.
         rsp_pending_q <= rsp_pending_d;
         rsp_owner_q   <= rsp_owner_d;
         rsp_err_q     <= rsp_err_d;
         ram_addr_q    <= ram_addr_d;
`ifdef MEM_PORT_ARB_RR_EN
         last_gnt_q    <= last_gnt_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Response outputs. rdata is forced to 0 unless a good read is completing.
   // ---------------------------------------------------------------------------
   always_comb begin
      if_rvalid = rsp_pending_q && (rsp_owner_q == OWNER_IF);
      ls_rvalid = rsp_pending_q && (rsp_owner_q == OWNER_LS);
      if_err    = if_rvalid && rsp_err_q;
      ls_err    = ls_rvalid && rsp_err_q;
      if_rdata  = (if_rvalid && !rsp_err_q) ? ram_rdata : '0;
      ls_rdata  = (ls_rvalid && !rsp_err_q) ? ram_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. It includes a behavioural single-port
// RAM. The RAM registers the address and write data on the rising edge, and
// its read data is combinational from the registered address. Inputs change
// 1 time unit after the rising edge. Outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int RAM_AW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt, if_rvalid, if_err;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req, ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt, ls_rvalid, ls_err;
   logic [DATA_W-1:0] ls_rdata;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .ls_err    (ls_err),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Behavioural RAM
   logic [DATA_W-1:0] mem [2**RAM_AW];
   logic [RAM_AW-1:0] raddr_q = '0;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      raddr_q <= ram_addr;
   end
   assign ram_rdata = mem[raddr_q];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Moves to the next cycle, just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lets the combinational logic settle after the inputs change.
   task automatic settle();
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2**RAM_AW; i++) mem[i] = '0;
      mem[0] = 32'hA000_0000;
      mem[1] = 32'hA111_1111;
      mem[2] = 32'hA222_2222;
      mem[4] = 32'hDEAD_BEEF;

      rst      = 1'b1;
      if_req   = 1'b1;   // requests held during reset must not be granted
      if_addr  = 32'h10;
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = 32'h20;
      ls_wdata = 32'h5555_5555;
      tick();
      tick();
      settle();
      check("rst if_gnt",    32'(if_gnt),    32'd0);
      check("rst ls_gnt",    32'(ls_gnt),    32'd0);
      check("rst ram_we",    32'(ram_we),    32'd0);
      check("rst ram_addr",  32'(ram_addr),  32'd0);
      check("rst ram_wdata", ram_wdata,      32'd0);
      check("rst if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst ls_rvalid", 32'(ls_rvalid), 32'd0);
      check("rst if_rdata",  if_rdata,       32'd0);

      rst    = 1'b0;
      if_req = 1'b0;
      ls_req = 1'b0;
      ls_we  = 1'b0;

      // 1: IF read of 0x10 (word 4)
      tick();
      if_req  = 1'b1;
      if_addr = 32'h10;
      settle();
      check("t1 if_gnt",   32'(if_gnt),   32'd1);
      check("t1 ls_gnt",   32'(ls_gnt),   32'd0);
      check("t1 ram_addr", 32'(ram_addr), 32'd4);
      check("t1 ram_we",   32'(ram_we),   32'd0);
      tick();
      if_req = 1'b0;
      settle();
      check("t1 if_rvalid", 32'(if_rvalid), 32'd1);
      check("t1 if_rdata",  if_rdata,       32'hDEAD_BEEF);
      check("t1 if_err",    32'(if_err),    32'd0);

      // 2: LS write 0x20, then LS read 0x20
      tick();
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = 32'h20;
      ls_wdata = 32'h1234_5678;
      settle();
      check("t2 ls_gnt w",   32'(ls_gnt),   32'd1);
      check("t2 ram_we",     32'(ram_we),   32'd1);
      check("t2 ram_addr",   32'(ram_addr), 32'd8);
      check("t2 ram_wdata",  ram_wdata,     32'h1234_5678);
      tick();
      ls_we = 1'b0;
      settle();
      check("t2 no wr rsp",  32'(ls_rvalid), 32'd0);
      check("t2 ls_gnt r",   32'(ls_gnt),    32'd1);
      check("t2 ram_we r",   32'(ram_we),    32'd0);
      tick();
      ls_req = 1'b0;
      settle();
      check("t2 ls_rvalid",  32'(ls_rvalid), 32'd1);
      check("t2 ls_rdata",   ls_rdata,       32'h1234_5678);
      check("t2 ls_err",     32'(ls_err),    32'd0);
      check("t2 if_rvalid",  32'(if_rvalid), 32'd0);

      // 5: IF reads back-to-back (this leaves IF as the last grant)
      tick();
      if_req  = 1'b1;
      if_addr = 32'h0;
      settle();
      check("t5 gnt0", 32'(if_gnt), 32'd1);
      tick();
      if_addr = 32'h4;
      settle();
      check("t5 gnt1",    32'(if_gnt),    32'd1);
      check("t5 rvalid0", 32'(if_rvalid), 32'd1);
      check("t5 rdata0",  if_rdata,       32'hA000_0000);
      tick();
      if_addr = 32'h8;
      settle();
      check("t5 gnt2",    32'(if_gnt),    32'd1);
      check("t5 rvalid1", 32'(if_rvalid), 32'd1);
      check("t5 rdata1",  if_rdata,       32'hA111_1111);
      tick();
      if_req = 1'b0;
      settle();
      check("t5 rvalid2",  32'(if_rvalid), 32'd1);
      check("t5 rdata2",   if_rdata,       32'hA222_2222);
      check("t5 idle gnt", 32'(if_gnt),    32'd0);
      check("t5 ram_addr hold", 32'(ram_addr), 32'd2);
      check("t5 idle we",  32'(ram_we),    32'd0);

      // 3: both requests held for 4 cycles
      tick();
      if_req  = 1'b1;
      if_addr = 32'h0;
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h4;
      for (int i = 0; i < 4; i++) begin
         logic exp_ls;
`ifdef MEM_PORT_ARB_RR_EN
         exp_ls = (i % 2 == 0);
`else
         exp_ls = 1'b1;
`endif
         settle();
         check($sformatf("t3 ls_gnt[%0d]", i), 32'(ls_gnt), 32'(exp_ls));
         check($sformatf("t3 if_gnt[%0d]", i), 32'(if_gnt), 32'(!exp_ls));
         tick();
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      tick();

      // 4: faulted accesses: misaligned read, then out-of-range write
      tick();
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h3;
      settle();
      check("t4 gnt mis",  32'(ls_gnt), 32'd1);
      check("t4 we mis",   32'(ram_we), 32'd0);
      tick();
      ls_we    = 1'b1;
      ls_addr  = 32'h400;
      ls_wdata = 32'hFFFF_FFFF;
      settle();
      check("t4 gnt oor",    32'(ls_gnt),    32'd1);
      check("t4 we oor",     32'(ram_we),    32'd0);
      check("t4 rvalid mis", 32'(ls_rvalid), 32'd1);
      check("t4 err mis",    32'(ls_err),    32'd1);
      check("t4 rdata mis",  ls_rdata,       32'd0);
      tick();
      ls_req = 1'b0;
      ls_we  = 1'b0;
      settle();
      check("t4 rvalid oor", 32'(ls_rvalid), 32'd1);
      check("t4 err oor",    32'(ls_err),    32'd1);
      check("t4 rdata oor",  ls_rdata,       32'd0);
      check("t4 mem0 kept",  mem[0],         32'hA000_0000);
      tick();
      check("t4 rvalid end", 32'(ls_rvalid), 32'd0);

      // 6: reset while an IF read is outstanding
      tick();
      if_req  = 1'b1;
      if_addr = 32'h10;
      settle();
      check("t6 if_gnt", 32'(if_gnt), 32'd1);
      tick();
      if_req = 1'b0;
      rst    = 1'b1;
      settle();
      check("t6 if_rvalid", 32'(if_rvalid), 32'd0);
      check("t6 if_rdata",  if_rdata,       32'd0);
      check("t6 ram_addr",  32'(ram_addr),  32'd0);
      check("t6 if_err",    32'(if_err),    32'd0);
      tick();
      rst = 1'b0;
      tick();
      settle();
      check("t6 rvalid after", 32'(if_rvalid), 32'd0);
      check("t6 ls_rvalid",    32'(ls_rvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
